gray_sync_rx: RTL and testbench
===============================

# gray_sync_rx

Receiving end of a Gray-coded counter crossing into the `clock` domain. It synchronizes an asynchronous Gray count (e.g. a FIFO pointer or frame counter produced by `bin2gray` in another domain) and converts it back to binary. It reports per-update step size, wrap-around and sticky multi-bit-change errors. It sits at the consumer side of every clock-domain crossing that uses Gray-encoded counters.

## Interface
- `WIDTH`, default 5: counter width in bits, at least 2.
- `SYNC_STAGES`, default 2: synchronizer flop depth, 2 or 3.
- `CHECK`, default 1: 1 enables single-bit-change checking; 0 ties `err_o` low.

- `clock`  in  1  block clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `gray_i`  in  WIDTH  Gray count from a foreign clock domain, asynchronous to `clock`.
- `clear_i`  in  1  clears sticky `err_o`.
- `gray_o`  out  WIDTH  synchronized, registered Gray value.
- `bin_o`  out  WIDTH  binary equivalent of `gray_o`.
- `delta_o`  out  WIDTH  (new `bin_o` − previous `bin_o`) mod 2^WIDTH, valid while `step_o`=1.
- `step_o`  out  1  one-cycle pulse when `bin_o` changes (primed only).
- `wrap_o`  out  1  one-cycle pulse when a step's new `bin_o` < old `bin_o` (unsigned).
- `err_o`  out  1  sticky: one update changed more than one Gray bit.

## Operation
- **Synchronizer.** `SYNC_STAGES` flops in series capture `gray_i`. No logic sits between the flops. The last stage is `gray_s`.
- **Decode.** `bin[WIDTH-1] = gray_s[WIDTH-1]`; `bin[i] = bin[i+1] ^ gray_s[i]`. The result is registered into `bin_o`, and `gray_s` is registered into `gray_o` on the same edge.
- **Change detection.** A change is `gray_s != gray_o`. On a change:
  - `delta_o <= bin_new − bin_o`, truncated to WIDTH bits.
  - `step_o <= 1` when PRIMED.
  - `wrap_o <= (bin_new < bin_o)` when PRIMED.
  - With no change, `step_o` and `wrap_o` are 0 and `delta_o` holds its last value.
- **State machine.** Two states: FILL and PRIMED.
  - Reset enters FILL and loads the fill counter with 0.
  - FILL: the fill counter counts clock cycles. `bin_o` and `gray_o` track normally, but `step_o`, `wrap_o` and error setting are suppressed.
  - FILL → PRIMED when the counter reaches `SYNC_STAGES`+1. This is `SYNC_STAGES`+1 edges after `reset` deasserts, after which the pipeline holds real data.
  - PRIMED persists until `reset`.
- **Error.** In PRIMED with `CHECK`=1, a change where popcount(`gray_s ^ gray_o`) > 1 sets `err_o`.
  - `err_o` clears on `clear_i` or `reset`.
  - Set and `clear_i` in the same cycle: set wins.
  - The update itself still proceeds: `bin_o` and `delta_o` reflect the jump and `step_o` pulses.
- **Wrap.** Stepping from all-ones to 0 gives `delta_o`=1 and `wrap_o`=1. A jump that crosses zero (e.g. 30→2) gives `delta_o`=4 and `wrap_o`=1.

## Timing
- **Reset values.** All synchronizer flops, `gray_o`, `bin_o` and `delta_o` are 0; `step_o`, `wrap_o` and `err_o` are 0; state is FILL.
- **Latency.** A `gray_i` change that is stable before edge k appears in `gray_s` after edge k+`SYNC_STAGES`−1. `bin_o`, `gray_o`, `step_o`, `delta_o` and `wrap_o` update together at edge k+`SYNC_STAGES`. With `SYNC_STAGES`=2, that is 2 edges.
- **Throughput.** One update per cycle. `gray_i` changing every cycle gives `step_o` high every cycle.
- **Reset mid-operation.** All state is discarded and the block re-enters FILL. A nonzero `gray_i` held across reset loads into `bin_o` during FILL with no `step_o` and no `err_o`.
- **Metastability.** Only the first synchronizer flop samples `gray_i`. `gray_i` must come from a register in the source domain.

## Test plan
Scenarios use `WIDTH`=5, `SYNC_STAGES`=2, `CHECK`=1.
- **Slow count.** Source counts 0..31..0 changing `gray_i` every 4 cycles → `bin_o` follows each value 2 edges later, `step_o` pulses per change, `delta_o`=1. `wrap_o`=1 only on 31→0. `err_o` stays 0.
- **Latency.** `gray_i` goes 00000→00001 just before edge k → `bin_o`=1, `step_o`=1 at edge k+2; `step_o`=0 at k+3.
- **Multi-step jump.** `gray_i` goes 00010 (3) → 00101 (6) → `delta_o`=3, `step_o`=1, `bin_o`=6, `err_o`=1 and held. Then `clear_i`=1 for one cycle → `err_o`=0. `clear_i` coincident with another bad jump → `err_o` stays 1.
- **Wrapping jump.** `bin_o` goes 30 → 2 → `delta_o`=4, `wrap_o`=1.
- **Reset with nonzero input.** `gray_i`=01111 (10) held through reset → after release, `bin_o`=10 within 3 edges, `step_o`, `wrap_o` and `err_o` stay 0. The next change to 01110 (11) gives `step_o`=1, `delta_o`=1.
- **Reset mid-count.** Assert `reset` while counting → all outputs 0 on the next edge, FILL is re-entered, and behaviour is identical to the previous scenario.

Source files
------------

// File: rtl/gray_sync_rx.sv
// Consumer side of a Gray-coded counter crossing: synchronize, decode to binary, and report
// step size, wrap-around and sticky multi-bit-change errors.
module gray_sync_rx #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CHECK       = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] delta_o,
  output logic             step_o,
  output logic             wrap_o,
  output logic             err_o
);

  typedef enum logic [0:0] {StFill, StPrimed} state_e;

  localparam int unsigned FillW = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] diff;
  logic             changed;
  logic             multi_bit;
  logic             set_err;
  state_e           state_q;
  logic [FillW-1:0] fill_q;

  // Plain flop chain; only sync_q[0] ever samples the asynchronous input.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_new = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_new[i] = ^(gray_s >> i);
    end
  end

  assign diff      = gray_s ^ gray_o;
  assign changed   = |diff;
  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign multi_bit = |(diff & (diff - WIDTH'(1)));
  assign set_err   = (CHECK != 0) && (state_q == StPrimed) && changed && multi_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFill;
      fill_q  <= '0;
      gray_o  <= '0;
      bin_o   <= '0;
      delta_o <= '0;
      step_o  <= 1'b0;
      wrap_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      gray_o <= gray_s;
      bin_o  <= bin_new;
      step_o <= 1'b0;
      wrap_o <= 1'b0;
      if (changed) begin
        delta_o <= bin_new - bin_o;
        if (state_q == StPrimed) begin
          step_o <= 1'b1;
          wrap_o <= (bin_new < bin_o);
        end
      end

      if (set_err) begin
        err_o <= 1'b1;
      end else if (clear_i) begin
        err_o <= 1'b0;
      end

      // Stay in fill until the synchronizer and output registers hold post-reset data.
      case (state_q)
        StFill: begin
          fill_q <= fill_q + FillW'(1);
          if (fill_q == FillW'(SYNC_STAGES)) begin
            state_q <= StPrimed;
          end
        end
        StPrimed: state_q <= StPrimed;
        default:  state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sync_rx.sv
// Directed bench for gray_sync_rx (WIDTH=5, SYNC_STAGES=2, CHECK=1).
module tb_gray_sync_rx;

  logic       clock;
  logic       reset;
  logic [4:0] gray_i;
  logic       clear_i;
  logic [4:0] gray_o;
  logic [4:0] bin_o;
  logic [4:0] delta_o;
  logic       step_o;
  logic       wrap_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  gray_sync_rx #(
    .WIDTH      (5),
    .SYNC_STAGES(2),
    .CHECK      (1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .gray_i (gray_i),
    .clear_i(clear_i),
    .gray_o (gray_o),
    .bin_o  (bin_o),
    .delta_o(delta_o),
    .step_o (step_o),
    .wrap_o (wrap_o),
    .err_o  (err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] b2g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  initial begin
    int b;
    reset   = 1'b1;
    gray_i  = 5'b00000;
    clear_i = 1'b0;
    tick();
    tick();
    check("rst_gray",  32'(gray_o),  0);
    check("rst_bin",   32'(bin_o),   0);
    check("rst_delta", 32'(delta_o), 0);
    check("rst_step",  32'(step_o),  0);
    check("rst_wrap",  32'(wrap_o),  0);
    check("rst_err",   32'(err_o),   0);
    reset = 1'b0;
    repeat (4) tick();

    // Latency: change before edge k, visible after edge k+2.
    gray_i = 5'b00001;
    tick();
    check("lat_k_bin", 32'(bin_o), 0);
    tick();
    check("lat_k1_bin",  32'(bin_o),  0);
    check("lat_k1_step", 32'(step_o), 0);
    tick();
    check("lat_k2_bin",   32'(bin_o),   1);
    check("lat_k2_step",  32'(step_o),  1);
    check("lat_k2_delta", 32'(delta_o), 1);
    check("lat_k2_wrap",  32'(wrap_o),  0);
    tick();
    check("lat_k3_step", 32'(step_o), 0);

    // Slow count 2..31 then 0, one change every 4 cycles.
    for (int n = 2; n <= 32; n++) begin
      b = n % 32;
      gray_i = b2g(b);
      tick();
      tick();
      check("slow_pre_step", 32'(step_o), 0);
      tick();
      check("slow_bin",   32'(bin_o),   32'(b));
      check("slow_gray",  32'(gray_o),  32'(b2g(b)));
      check("slow_step",  32'(step_o),  1);
      check("slow_delta", 32'(delta_o), 1);
      check("slow_wrap",  32'(wrap_o),  32'(b == 0));
      tick();
      check("slow_post_step", 32'(step_o), 0);
    end
    check("slow_err", 32'(err_o), 0);

    // Throughput: change every cycle 1,2,3.
    gray_i = b2g(1);
    tick();
    gray_i = b2g(2);
    tick();
    gray_i = b2g(3);
    tick();
    check("tp_bin1",  32'(bin_o),  1);
    check("tp_step1", 32'(step_o), 1);
    tick();
    check("tp_bin2",  32'(bin_o),  2);
    check("tp_step2", 32'(step_o), 1);
    tick();
    check("tp_bin3",   32'(bin_o),   3);
    check("tp_step3",  32'(step_o),  1);
    check("tp_delta3", 32'(delta_o), 1);
    tick();
    check("tp_idle_step", 32'(step_o), 0);
    check("tp_err",       32'(err_o),  0);

    // Multi-step jump 3 -> 6 (00010 -> 00101).
    gray_i = 5'b00101;
    tick();
    tick();
    tick();
    check("jump_bin",   32'(bin_o),   6);
    check("jump_delta", 32'(delta_o), 3);
    check("jump_step",  32'(step_o),  1);
    check("jump_err",   32'(err_o),   1);
    tick();
    check("jump_err_held", 32'(err_o),  1);
    check("jump_step_off", 32'(step_o), 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_err", 32'(err_o), 0);

    // Bad jump 6 -> 10 with clear on the same edge: set wins.
    gray_i = 5'b01111;
    tick();
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("setclr_bin",   32'(bin_o),   10);
    check("setclr_delta", 32'(delta_o), 4);
    check("setclr_err",   32'(err_o),   1);
    tick();
    check("setclr_held", 32'(err_o), 1);

    // Wrapping jump 30 -> 2.
    gray_i = 5'b10001;
    repeat (3) tick();
    check("wrapj_bin30", 32'(bin_o), 30);
    gray_i = 5'b00011;
    tick();
    tick();
    tick();
    check("wrapj_bin",   32'(bin_o),   2);
    check("wrapj_delta", 32'(delta_o), 4);
    check("wrapj_wrap",  32'(wrap_o),  1);
    check("wrapj_step",  32'(step_o),  1);
    check("wrapj_err",   32'(err_o),   1);

    // Reset mid-count with nonzero input held across it.
    gray_i = 5'b01111;
    reset  = 1'b1;
    tick();
    check("mrst_bin",   32'(bin_o),   0);
    check("mrst_gray",  32'(gray_o),  0);
    check("mrst_delta", 32'(delta_o), 0);
    check("mrst_step",  32'(step_o),  0);
    check("mrst_wrap",  32'(wrap_o),  0);
    check("mrst_err",   32'(err_o),   0);
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("fill_step", 32'(step_o), 0);
      check("fill_wrap", 32'(wrap_o), 0);
      check("fill_err",  32'(err_o),  0);
    end
    check("fill_bin", 32'(bin_o), 10);
    gray_i = 5'b01110;
    tick();
    tick();
    tick();
    check("post_bin",   32'(bin_o),   11);
    check("post_step",  32'(step_o),  1);
    check("post_delta", 32'(delta_o), 1);
    check("post_err",   32'(err_o),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
